// File: rtl/sht21_iic_responder.sv
// SHT21-style IIC responder: acknowledges the measurement master's address and
// command, then serves a latched 16-bit word followed by its CRC-8.
module sht21_iic_responder #(
    parameter logic [6:0]  DEV_ADDR = 7'h40,
    parameter logic [7:0]  CMD_TEM  = 8'hE3,
    parameter logic [7:0]  CMD_HUM  = 8'hE5,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned HOLD_CYC = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scl_in,
    input  logic        i_sda_in,
    output logic        o_sda_oe,
    input  logic [15:0] i_tem_data,
    input  logic [15:0] i_hum_data,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd_code,
    output logic        o_busy
);

    localparam int unsigned FCW = $clog2(FILT_LEN + 1);
    localparam int unsigned HCW = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        StIdle, StAddr, StWAck, StCmd, StCAck, StWaitRs, StRAck, StTx, StMAck, StIgnore
    } state_e;

    // Bit 1 carries SCL, bit 0 carries SDA.
    logic [1:0]     r_meta, r_sync, r_filt, r_filt_q;
    logic [FCW-1:0] r_fcnt [2];

    state_e         r_state, w_state_d;
    logic [2:0]     r_bit_cnt, w_bit_cnt_d;
    logic [7:0]     r_shift, w_shift_d, w_shift_in;
    logic [1:0]     r_idx, w_idx_d;
    logic           r_busy, w_busy_d;
    logic [7:0]     r_cmd_code, w_cmd_code_d;
    logic           r_cmd_valid, w_cmd_valid_d;
    logic [15:0]    r_snapshot, w_snapshot_d;
    logic           r_snap_valid, w_snap_valid_d;
    logic [HCW-1:0] r_hold_cnt;
    logic           r_sda_oe;

    logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_crc, w_tx_byte;
    logic       w_oe_target;

    function automatic logic [7:0] crc8(input logic [15:0] data);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ 8'h31;
            else                  crc = {crc[6:0], 1'b0};
        end
        return crc;
    endfunction

    // A new level is accepted only after FILT_LEN consecutive differing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta   <= 2'b11;
            r_sync   <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_meta   <= {i_scl_in, i_sda_in};
            r_sync   <= r_meta;
            r_filt_q <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FCW'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCW'(1);
                end
            end
        end
    end

    assign w_sda      = r_filt[0];
    assign w_scl_rise = r_filt[1] & ~r_filt_q[1];
    assign w_scl_fall = ~r_filt[1] & r_filt_q[1];
    assign w_start    = r_filt[1] & r_filt_q[1] & r_filt_q[0] & ~r_filt[0];
    assign w_stop     = r_filt[1] & r_filt_q[1] & ~r_filt_q[0] & r_filt[0];
    assign w_shift_in = {r_shift[6:0], w_sda};

    assign w_crc     = crc8(r_snapshot);
    assign w_tx_byte = (r_idx == 2'd0) ? r_snapshot[15:8] :
                       (r_idx == 2'd1) ? r_snapshot[7:0]  : w_crc;

    always_comb begin
        w_state_d      = r_state;
        w_bit_cnt_d    = r_bit_cnt;
        w_shift_d      = r_shift;
        w_idx_d        = r_idx;
        w_busy_d       = r_busy;
        w_cmd_code_d   = r_cmd_code;
        w_cmd_valid_d  = 1'b0;
        w_snapshot_d   = r_snapshot;
        w_snap_valid_d = r_snap_valid;
        if (w_stop) begin
            w_state_d   = StIdle;
            w_busy_d    = 1'b0;
            w_bit_cnt_d = 3'd0;
        end else if (w_start) begin
            w_state_d   = StAddr;
            w_bit_cnt_d = 3'd0;
        end else if (w_scl_rise) begin
            case (r_state)
                StAddr: begin
                    w_shift_d   = w_shift_in;
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (w_shift_in == {DEV_ADDR, 1'b0}) begin
                            w_state_d = StWAck;
                            w_busy_d  = 1'b1;
                        end else if (w_shift_in == {DEV_ADDR, 1'b1} && r_snap_valid) begin
                            w_state_d = StRAck;
                            w_busy_d  = 1'b1;
                            w_idx_d   = 2'd0;
                        end else begin
                            w_state_d = StIgnore;
                        end
                    end
                end
                StWAck: begin
                    w_state_d   = StCmd;
                    w_bit_cnt_d = 3'd0;
                end
                StCmd: begin
                    w_shift_d   = w_shift_in;
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (w_shift_in == CMD_TEM || w_shift_in == CMD_HUM) begin
                            w_state_d      = StCAck;
                            w_cmd_code_d   = w_shift_in;
                            w_cmd_valid_d  = 1'b1;
                            w_snap_valid_d = 1'b1;
                            w_snapshot_d   = (w_shift_in == CMD_TEM) ? i_tem_data : i_hum_data;
                        end else begin
                            w_state_d = StIgnore;
                        end
                    end
                end
                StCAck: w_state_d = StWaitRs;
                StRAck: begin
                    w_state_d   = StTx;
                    w_bit_cnt_d = 3'd0;
                end
                StTx: begin
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_d = StMAck;
                end
                StMAck: begin
                    if (!w_sda && r_idx != 2'd2) begin
                        w_idx_d     = r_idx + 2'd1;
                        w_state_d   = StTx;
                        w_bit_cnt_d = 3'd0;
                    end else begin
                        w_state_d = StIgnore;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_idx        <= 2'd0;
            r_busy       <= 1'b0;
            r_cmd_code   <= 8'h00;
            r_cmd_valid  <= 1'b0;
            r_snapshot   <= 16'h0000;
            r_snap_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_shift      <= w_shift_d;
            r_idx        <= w_idx_d;
            r_busy       <= w_busy_d;
            r_cmd_code   <= w_cmd_code_d;
            r_cmd_valid  <= w_cmd_valid_d;
            r_snapshot   <= w_snapshot_d;
            r_snap_valid <= w_snap_valid_d;
        end
    end

    // The state settles at an SCL rise; the matching SDA level is applied only
    // HOLD_CYC cycles into the following low phase.
    assign w_oe_target = (r_state == StWAck) || (r_state == StCAck) || (r_state == StRAck) ||
                         ((r_state == StTx) && !w_tx_byte[3'd7 - r_bit_cnt]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt <= '0;
            r_sda_oe   <= 1'b0;
        end else if (w_start || w_stop) begin
            r_hold_cnt <= '0;
            r_sda_oe   <= 1'b0;
        end else if (w_scl_fall) begin
            r_hold_cnt <= HCW'(HOLD_CYC);
        end else if (w_scl_rise) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HCW'(1);
            if (r_hold_cnt == HCW'(1)) r_sda_oe <= w_oe_target;
        end
    end

    assign o_sda_oe    = r_sda_oe;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_code  = r_cmd_code;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_sht21_iic_responder.sv
// Bench for sht21_iic_responder: bit-banged IIC master with open-drain SDA and a
// transaction-level model of the expected sensor replies.
module tb_sht21_iic_responder;

    localparam int Q = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1, m_sda = 1'b1;
    logic        g_scl = 1'b0, g_sda = 1'b0, glitch_on = 1'b0;
    logic [15:0] tem = 16'h0000, hum = 16'h0000;
    logic        sda_oe, cmd_valid, busy;
    logic [7:0]  cmd_code;
    logic        sda_line, scl_pin, sda_pin;
    logic        last_oe = 1'b0, prev_oe = 1'b0;
    int          n_checks = 0, n_err = 0, cv_cnt = 0, viol = 0;

    // Transaction-level model of the responder.
    logic        snap_ok = 1'b0;
    logic [15:0] snap_m = 16'h0000;
    logic [7:0]  code_m = 8'h00;
    logic [7:0]  rd_bytes [3];

    assign sda_line = m_sda & ~sda_oe;
    assign scl_pin  = m_scl ^ g_scl;
    assign sda_pin  = sda_line ^ g_sda;

    sht21_iic_responder dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl_in    (scl_pin),
        .i_sda_in    (sda_pin),
        .o_sda_oe    (sda_oe),
        .i_tem_data  (tem),
        .i_hum_data  (hum),
        .o_cmd_valid (cmd_valid),
        .o_cmd_code  (cmd_code),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid) cv_cnt <= cv_cnt + 1;
        if (!rst && m_scl && sda_oe !== prev_oe) viol <= viol + 1;
        prev_oe <= sda_oe;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of word*x^8 divided by x^8+x^5+x^4+1.
    function automatic logic [7:0] crc_ref(input logic [15:0] w);
        logic [23:0] v;
        v = {w, 8'h00};
        for (int b = 23; b >= 8; b--) if (v[b]) v = v ^ (24'h000131 << (b - 8));
        return v[7:0];
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        if (i == 0) return snap_m[15:8];
        if (i == 1) return snap_m[7:0];
        return crc_ref(snap_m);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sda();
        g_sda = 1'b1; wait_clks(1); g_sda = 1'b0;
    endtask

    task automatic pulse_scl();
        g_scl = 1'b1; wait_clks(1); g_scl = 1'b0;
    endtask

    task automatic bit_io(input logic b, output logic r);
        m_sda = b;
        wait_clks(Q);
        m_scl = 1'b1;
        wait_clks(Q / 2);
        if (glitch_on) pulse_sda();
        wait_clks(Q / 2);
        r       = sda_line;
        last_oe = sda_oe;
        wait_clks(Q);
        m_scl = 1'b0;
        wait_clks(Q / 2);
        if (glitch_on) pulse_scl();
        wait_clks(Q / 2);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b1; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b, output logic rel9);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            b[i] = r;
        end
        bit_io(~mack, r);
        rel9 = ~last_oe;
    endtask

    task automatic do_cmd(input logic [7:0] cmd);
        logic ack, ok;
        int   cv0;
        ok = (cmd == 8'hE3) || (cmd == 8'hE5);
        i2c_start();
        write_byte(8'h80, ack);
        check_eq("wr_addr_ack", ack, 1);
        check_eq("busy_after_addr", busy, 1);
        cv0 = cv_cnt;
        write_byte(cmd, ack);
        if (ok) begin
            snap_ok = 1'b1;
            snap_m  = (cmd == 8'hE3) ? tem : hum;
            code_m  = cmd;
        end
        check_eq("cmd_ack", ack, ok);
        check_eq("cmd_valid_pulses", cv_cnt - cv0, ok ? 1 : 0);
        check_eq("cmd_code", cmd_code, code_m);
    endtask

    task automatic do_read(input int n);
        logic       ack, rel, r;
        logic [7:0] b;
        i2c_start();
        write_byte(8'h81, ack);
        check_eq("rd_addr_ack", ack, snap_ok);
        if (ack && snap_ok) begin
            check_eq("busy_in_read", busy, 1);
            for (int i = 0; i < n; i++) begin
                read_byte(i < n - 1, b, rel);
                rd_bytes[i] = b;
                check_eq("rd_byte", b, exp_byte(i));
                if (i == n - 1) check_eq("released_9th", rel, 1);
            end
            bit_io(1'b1, r);
            check_eq("released_after_nack", last_oe, 0);
        end
        i2c_stop();
        check_eq("busy_after_stop", busy, 0);
        check_eq("oe_after_stop", sda_oe, 0);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] c;
        int         k;

        wait_clks(5);
        check_eq("rst_oe", sda_oe, 0);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_cmd_code", cmd_code, 8'h00);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        wait_clks(10);

        // Read with no snapshot is refused.
        do_read(1);

        // Temperature measurement with full 3-byte read.
        tem = 16'h683A;
        do_cmd(8'hE3);
        do_read(3);
        check_eq("t2_ms", rd_bytes[0], 8'h68);
        check_eq("t2_ls", rd_bytes[1], 8'h3A);
        check_eq("t2_crc", rd_bytes[2], 8'h7C);

        // Humidity, stop before CRC.
        hum = 16'h4E85;
        do_cmd(8'hE5);
        do_read(2);
        check_eq("t3_ms", rd_bytes[0], 8'h4E);
        check_eq("t3_ls", rd_bytes[1], 8'h85);

        // Foreign address and unknown command.
        k = cv_cnt;
        i2c_start();
        write_byte(8'h82, ack);
        check_eq("foreign_addr_ack", ack, 0);
        check_eq("foreign_busy", busy, 0);
        check_eq("foreign_cmd_valid", cv_cnt - k, 0);
        i2c_stop();
        do_cmd(8'hF3);
        i2c_stop();

        // Single-cycle glitches on both lines during a full transfer.
        glitch_on = 1'b1;
        hum = 16'($urandom);
        do_cmd(8'hE5);
        do_read(3);
        glitch_on = 1'b0;

        // STOP in the middle of a transmitted byte.
        tem = 16'hF00F;
        do_cmd(8'hE3);
        i2c_start();
        write_byte(8'h81, ack);
        check_eq("midtx_addr_ack", ack, 1);
        bit_io(1'b1, r);
        check_eq("midtx_bit7", r, 1);
        bit_io(1'b1, r);
        check_eq("midtx_bit6", r, 1);
        i2c_stop();
        check_eq("midtx_oe", sda_oe, 0);
        check_eq("midtx_busy", busy, 0);
        do_read(1);
        check_eq("midtx_after", rd_bytes[0], 8'hF0);

        // Reset while the responder is driving a 0 data bit.
        tem = 16'h683A;
        do_cmd(8'hE3);
        i2c_start();
        write_byte(8'h81, ack);
        wait_clks(2);
        check_eq("tx0_driving", sda_oe, 1);
        #3 rst = 1'b1;
        #1;
        check_eq("rst_mid_oe", sda_oe, 0);
        check_eq("rst_mid_busy", busy, 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clks(4);
        check_eq("rst_mid_code", cmd_code, 8'h00);
        rst     = 1'b0;
        snap_ok = 1'b0;
        code_m  = 8'h00;
        wait_clks(10);
        do_read(1);
        hum = 16'($urandom);
        do_cmd(8'hE5);
        do_read(3);

        // Randomized command/read mix; inputs change while words are in flight.
        for (int it = 0; it < 10; it++) begin
            tem = 16'($urandom);
            hum = 16'($urandom);
            k   = int'($urandom_range(0, 3));
            if (k < 3) begin
                c = (k == 0) ? 8'hE3 : (k == 1) ? 8'hE5 : (8'hF3 ^ (8'($urandom) & 8'h0C));
                do_cmd(c);
                tem = 16'($urandom);
                hum = 16'($urandom);
            end
            do_read(int'($urandom_range(1, 3)));
        end

        check_eq("oe_change_while_scl_high", viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
